// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP types, status bits and constants for the multiplier/divider datapath
package fp_pkg;
  localparam int QBITS = 26;

  typedef enum logic [2:0] {
    RND_NEAR    = 3'b000,
    RND_ZERO    = 3'b001,
    RND_PINF    = 3'b010,
    RND_NINF    = 3'b011,
    RND_NEAR_UP = 3'b100,
    RND_AWAY    = 3'b101
  } rnd_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  localparam logic [31:0] NAN_CANON = 32'h7FC0_0000;
  localparam logic [31:0] INF       = 32'h7F80_0000;
  localparam logic [31:0] MAX_NORM  = 32'h7F7F_FFFF;
  localparam logic [31:0] MIN_NORM  = 32'h0080_0000;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  // Result class of a/b from the operand magnitudes; denormals count as zero.
  function automatic fp_class_t div_class(input logic [30:0] a, input logic [30:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
    b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return CLS_NAN;
    else if (a_inf || b_zero)                                     return CLS_INF;
    else if (a_zero || b_inf)                                     return CLS_ZERO;
    else                                                          return CLS_NORM;
  endfunction
endpackage

// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - operand/result handshake bundle of the sequential divider
interface fp_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  rnd;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] z;
  logic [7:0]  status;

  modport master (output in_valid, rnd, a, b, input in_ready, out_valid, z, status);
  modport slave  (input in_valid, rnd, a, b, output in_ready, out_valid, z, status);
endinterface

// File: rtl/fp_div_round.sv
// rtl/fp_div_round.sv - combinational rounding and exception unit for the divider
module fp_div_round
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] e_i,
  input  logic [23:0]       sig_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  rnd_t              rnd_i,
  input  fp_class_t         cls_i,
  output logic [31:0]       z_o,
  output logic [7:0]        status_o
);
  logic              inexact, inc, dir_away;
  logic [24:0]       sum;
  logic [22:0]       frac_r;
  logic signed [9:0] e_r;

  always_comb begin
    inexact = guard_i | sticky_i;
    case (rnd_i)
      RND_ZERO:    inc = 1'b0;
      RND_PINF:    inc = inexact & ~sign_i;
      RND_NINF:    inc = inexact & sign_i;
      RND_NEAR_UP: inc = guard_i;
      RND_AWAY:    inc = inexact;
      default:     inc = guard_i & (sticky_i | sig_i[0]);
    endcase
    // Directed rounding toward the result's sign moves away from zero.
    dir_away = ((rnd_i == RND_PINF) && !sign_i) || ((rnd_i == RND_NINF) && sign_i);

    sum    = {1'b0, sig_i} + {24'd0, inc};
    frac_r = sum[24] ? sum[23:1] : sum[22:0];
    e_r    = sum[24] ? e_i + 10'sd1 : e_i;

    z_o      = 32'd0;
    status_o = 8'd0;
    case (cls_i)
      CLS_NAN: begin
        z_o              = NAN_CANON;
        status_o[ST_NAN] = 1'b1;
      end
      CLS_INF: begin
        z_o              = {sign_i, INF[30:0]};
        status_o[ST_INF] = 1'b1;
      end
      CLS_ZERO: begin
        z_o               = {sign_i, 31'd0};
        status_o[ST_ZERO] = 1'b1;
      end
      default: begin
        if (e_r >= 10'sd255) begin
          status_o[ST_HUGE]    = 1'b1;
          status_o[ST_INEXACT] = 1'b1;
          if (rnd_i == RND_NEAR || rnd_i == RND_NEAR_UP || rnd_i == RND_AWAY || dir_away) begin
            z_o              = {sign_i, INF[30:0]};
            status_o[ST_INF] = 1'b1;
          end else begin
            z_o = {sign_i, MAX_NORM[30:0]};
          end
        end else if (e_r <= 10'sd0) begin
          status_o[ST_TINY]    = 1'b1;
          status_o[ST_INEXACT] = 1'b1;
          if (rnd_i == RND_AWAY || dir_away) begin
            z_o = {sign_i, MIN_NORM[30:0]};
          end else begin
            z_o               = {sign_i, 31'd0};
            status_o[ST_ZERO] = 1'b1;
          end
        end else begin
          z_o                  = {sign_i, e_r[7:0], frac_r};
          status_o[ST_INEXACT] = inexact;
        end
      end
    endcase
  end
endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential radix-2 restoring IEEE-754 single divider
// Optional FP_DIV_EARLY_EXIT_EN: special-class operands bypass the DIVIDE iterations.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  fp_div_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND, S_DONE} state_t;
  localparam logic [4:0] LAST_STEP = 5'(QBITS - 1);

  state_t            state_q, state_d;
  logic              sign_q;
  logic signed [9:0] e_q;
  rnd_t              rnd_q;
  fp_class_t         cls_q;
  logic [23:0]       mb_q;
  logic [24:0]       r_q;
  logic [QBITS-1:0]  q_q;
  logic [4:0]        cnt_q;
  logic [31:0]       res_z_q, z_q;
  logic [7:0]        res_st_q, status_q;
  logic              out_valid_q;

  logic              accept, ge, q_hi;
  fp_class_t         cls_in;
  logic signed [9:0] e_in, e_rnd;
  logic [23:0]       r_sub;
  logic [31:0]       rnd_z;
  logic [7:0]        rnd_st;

  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign cls_in = div_class(bus.a[30:0], bus.b[30:0]);
  assign e_in   = $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + 10'sd127;

  // Remainder is always below 2*mb, so the low 24 bits of the difference suffice.
  assign ge    = (r_q >= {1'b0, mb_q});
  assign r_sub = r_q[23:0] - mb_q;

  // Leading quotient bit clear means ma < mb: quotient in [0.5,1), exponent one lower.
  assign q_hi  = q_q[QBITS-1];
  assign e_rnd = q_hi ? e_q : e_q - 10'sd1;

  fp_div_round u_round (
    .sign_i   (sign_q),
    .e_i      (e_rnd),
    .sig_i    (q_hi ? q_q[25:2] : q_q[24:1]),
    .guard_i  (q_hi ? q_q[1] : q_q[0]),
    .sticky_i ((q_hi & q_q[0]) | (|r_q)),
    .rnd_i    (rnd_q),
    .cls_i    (cls_q),
    .z_o      (rnd_z),
    .status_o (rnd_st)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef FP_DIV_EARLY_EXIT_EN
          state_d = (cls_in == CLS_NORM) ? S_DIVIDE : S_ROUND;
`else
          state_d = S_DIVIDE;
`endif
        end
      end
      S_DIVIDE: if (cnt_q == LAST_STEP) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q      <= 1'b0;
      e_q         <= '0;
      rnd_q       <= RND_NEAR;
      cls_q       <= CLS_NORM;
      mb_q        <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      res_z_q     <= '0;
      res_st_q    <= '0;
      z_q         <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        sign_q <= bus.a[31] ^ bus.b[31];
        e_q    <= e_in;
        rnd_q  <= rnd_t'(bus.rnd);
        cls_q  <= cls_in;
        mb_q   <= {1'b1, bus.b[22:0]};
        r_q    <= {2'b01, bus.a[22:0]};
        q_q    <= '0;
        cnt_q  <= '0;
      end else if (state_q == S_DIVIDE) begin
        r_q   <= ge ? {r_sub, 1'b0} : {r_q[23:0], 1'b0};
        q_q   <= {q_q[QBITS-2:0], ge};
        cnt_q <= cnt_q + 5'd1;
      end
      if (state_q == S_ROUND) begin
        res_z_q  <= rnd_z;
        res_st_q <= rnd_st;
      end
      out_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        z_q      <= res_z_q;
        status_q <= res_st_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.status    = status_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - scoreboard bench for the sequential FP divider
module tb_fp_div_seq;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  r;
    logic [31:0] z;
    logic [7:0]  st;
    logic        spec;
  } vec_t;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  st;
    logic        spec;
  } exp_t;

`ifdef FP_DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  fp_div_seq_if bus ();
  fp_div_seq dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic spec);
    return (spec && EARLY) ? 2 : 28;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.rnd = r; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'hDEAD_BEEF; bus.rnd = 3'b111;
  endtask

  task automatic issue(input vec_t v);
    sb.push_back('{v.z, v.st, v.spec});
    send(v.a, v.b, v.r);
  endtask

  task automatic collect(output logic [31:0] z, output logic [7:0] st, output int lat, output bit to);
    lat = 0; to = 1'b1; z = '0; st = '0;
    for (int i = 0; i < TMO; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) begin
        to = 1'b0; z = bus.z; st = bus.status;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.rnd = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    if (bus.z !== 32'd0) begin failures++; $display("FAIL reset z: got %h expected 00000000", bus.z); end
    if (bus.status !== 8'd0) begin failures++; $display("FAIL reset status: got %h expected 00", bus.status); end
    rst_n = 1'b1;
  endtask

  task automatic test_rounding;
    vec_t v[9];
    logic [31:0] z; logic [7:0] st; int lat; bit to; exp_t e;
    v[0] = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, 1'b0};
    v[1] = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 8'h20, 1'b0};
    v[2] = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 8'h20, 1'b0};
    v[3] = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAB, 8'h20, 1'b0};
    v[4] = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAA, 8'h20, 1'b0};
    v[5] = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 8'h20, 1'b0};
    v[6] = '{32'h3F800000, 32'h40400000, 3'd5, 32'h3EAAAAAB, 8'h20, 1'b0};
    v[7] = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAA, 8'h20, 1'b0};
    v[8] = '{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAB, 8'h20, 1'b0};
    for (int i = 0; i < 9; i++) begin
      issue(v[i]);
      collect(z, st, lat, to);
      e = sb.pop_front();
      checks++;
      if (to) begin failures++; $display("FAIL rounding[%0d] timeout: no out_valid in %0d cycles", i, TMO); end
      else begin
        checks += 3;
        if (z !== e.z) begin failures++; $display("FAIL rounding[%0d] z: got %h expected %h", i, z, e.z); end
        if (st !== e.st) begin failures++; $display("FAIL rounding[%0d] status: got %h expected %h", i, st, e.st); end
        if (lat != exp_lat(e.spec)) begin failures++; $display("FAIL rounding[%0d] latency: got %0d expected %0d", i, lat, exp_lat(e.spec)); end
      end
    end
  endtask

  task automatic test_specials;
    vec_t v[10];
    logic [31:0] z; logic [7:0] st; int lat; bit to; exp_t e;
    v[0] = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 8'h02, 1'b1};
    v[1] = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04, 1'b1};
    v[2] = '{32'h00000000, 32'h40000000, 3'd0, 32'h00000000, 8'h01, 1'b1};
    v[3] = '{32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000, 8'h02, 1'b1};
    v[4] = '{32'h40000000, 32'h7F800000, 3'd0, 32'h00000000, 8'h01, 1'b1};
    v[5] = '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04, 1'b1};
    v[6] = '{32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 8'h04, 1'b1};
    v[7] = '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 8'h01, 1'b1};
    v[8] = '{32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 8'h02, 1'b1};
    v[9] = '{32'h00000001, 32'h40000000, 3'd0, 32'h00000000, 8'h01, 1'b1};
    for (int i = 0; i < 10; i++) begin
      issue(v[i]);
      collect(z, st, lat, to);
      e = sb.pop_front();
      checks++;
      if (to) begin failures++; $display("FAIL special[%0d] timeout: no out_valid in %0d cycles", i, TMO); end
      else begin
        checks += 3;
        if (z !== e.z) begin failures++; $display("FAIL special[%0d] z: got %h expected %h", i, z, e.z); end
        if (st !== e.st) begin failures++; $display("FAIL special[%0d] status: got %h expected %h", i, st, e.st); end
        if (lat != exp_lat(e.spec)) begin failures++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, exp_lat(e.spec)); end
      end
    end
  endtask

  task automatic test_range;
    vec_t v[9];
    logic [31:0] z; logic [7:0] st; int lat; bit to; exp_t e;
    v[0] = '{32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 8'h32, 1'b0};
    v[1] = '{32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 8'h30, 1'b0};
    v[2] = '{32'h7F000000, 32'h3E800000, 3'd2, 32'h7F800000, 8'h32, 1'b0};
    v[3] = '{32'h7F000000, 32'h3E800000, 3'd3, 32'h7F7FFFFF, 8'h30, 1'b0};
    v[4] = '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 8'h29, 1'b0};
    v[5] = '{32'h00800000, 32'h40000000, 3'd2, 32'h00800000, 8'h28, 1'b0};
    v[6] = '{32'h00800000, 32'h40000000, 3'd5, 32'h00800000, 8'h28, 1'b0};
    v[7] = '{32'h00800000, 32'h40000000, 3'd3, 32'h00000000, 8'h29, 1'b0};
    v[8] = '{32'h80800000, 32'h40000000, 3'd3, 32'h80800000, 8'h28, 1'b0};
    for (int i = 0; i < 9; i++) begin
      issue(v[i]);
      collect(z, st, lat, to);
      e = sb.pop_front();
      checks++;
      if (to) begin failures++; $display("FAIL range[%0d] timeout: no out_valid in %0d cycles", i, TMO); end
      else begin
        checks += 3;
        if (z !== e.z) begin failures++; $display("FAIL range[%0d] z: got %h expected %h", i, z, e.z); end
        if (st !== e.st) begin failures++; $display("FAIL range[%0d] status: got %h expected %h", i, st, e.st); end
        if (lat != exp_lat(e.spec)) begin failures++; $display("FAIL range[%0d] latency: got %0d expected %0d", i, lat, exp_lat(e.spec)); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] z; logic [7:0] st; int lat; bit to; exp_t e;
    issue('{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, 1'b0});
    collect(z, st, lat, to);
    e = sb.pop_front();
    checks += 2;
    if (to || z !== e.z) begin failures++; $display("FAIL b2b first z: got %h expected %h (timeout=%0b)", z, e.z, to); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b in_ready after done: got %b expected 1", bus.in_ready); end
    issue('{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 8'h20, 1'b0});
    checks++;
    if (bus.z !== 32'h40400000) begin failures++; $display("FAIL b2b z hold: got %h expected 40400000", bus.z); end
    collect(z, st, lat, to);
    e = sb.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL b2b second timeout: no out_valid in %0d cycles", TMO); end
    else begin
      checks += 3;
      if (z !== e.z) begin failures++; $display("FAIL b2b second z: got %h expected %h", z, e.z); end
      if (st !== e.st) begin failures++; $display("FAIL b2b second status: got %h expected %h", st, e.st); end
      if (lat != 28) begin failures++; $display("FAIL b2b second latency: got %0d expected 28", lat); end
    end
  endtask

  task automatic test_busy_ignored;
    logic [31:0] z; logic [7:0] st; int lat; bit to; exp_t e; int pulses;
    issue('{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, 1'b0});
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL busy in_ready: got %b expected 0", bus.in_ready); end
    bus.a = 32'h3F800000; bus.b = 32'h00000000; bus.rnd = 3'd0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    collect(z, st, lat, to);
    e = sb.pop_front();
    checks += 2;
    if (to || z !== e.z || st !== e.st) begin failures++; $display("FAIL busy result: got %h/%h expected %h/%h (timeout=%0b)", z, st, e.z, e.st, to); end
    @(posedge clk);
    #1;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL busy pulse width: out_valid got %b expected 0", bus.out_valid); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL busy extra out_valid: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] z; logic [7:0] st; int lat; bit to; exp_t e; int pulses;
    send(32'h3F800000, 32'h40400000, 3'd0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid in_ready: got %b expected 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid out_valid: got %b expected 0", bus.out_valid); end
    if (bus.z !== 32'd0) begin failures++; $display("FAIL rst_mid z: got %h expected 00000000", bus.z); end
    if (bus.status !== 8'd0) begin failures++; $display("FAIL rst_mid status: got %h expected 00", bus.status); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL rst_mid stale out_valid: got %0d pulses expected 0", pulses); end
    issue('{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, 1'b0});
    collect(z, st, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || z !== e.z || st !== e.st || lat != 28) begin
      failures++;
      $display("FAIL rst_mid recovery: got %h/%h lat %0d expected %h/%h lat 28 (timeout=%0b)", z, st, lat, e.z, e.st, to);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_specials();
    test_range();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
